// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package chunked_serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int calc_nch(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Chunk index width; a single-chunk adder still needs a 1-bit index.
   function automatic int calc_kw(input int nch);
      return (nch <= 1) ? 1 : $clog2(nch);
   endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit adder slice, also exposing the carry into its MSB.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             carry_in,
   output logic [CHUNK-1:0] sum,
   output logic             carry_out,
   output logic             carry_msb
);

   logic [CHUNK:0] total_s;

   // Full-width add; the MSB carry-in is recovered from the MSB sum bit.
   always_comb begin
      total_s   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry_in};
      sum       = total_s[CHUNK-1:0];
      carry_out = total_s[CHUNK];
      carry_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ total_s[CHUNK-1];
   end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock, LSB chunk first, then
// commits sum, carry_out and overflow together with a one-cycle done pulse.
module chunked_serial_adder
   import chunked_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int NCH = calc_nch(WIDTH, CHUNK);
   localparam int KW  = calc_kw(NCH);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("chunked_serial_adder: WIDTH must be an integer multiple of CHUNK");
   end

   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;
   logic [KW-1:0]    k_r;
   logic [WIDTH-1:0] work_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry_out_r;
   logic             overflow_r;
   logic             done_r;
   logic             busy_r;

   logic [31:0]      shift_s;
   logic [CHUNK-1:0] a_chunk_s;
   logic [CHUNK-1:0] b_chunk_s;
   logic [CHUNK-1:0] chunk_sum_s;
   logic             chunk_co_s;
   logic             chunk_cmsb_s;
   logic [WIDTH-1:0] work_next_s;
   logic             last_s;

   // Select chunk k of each operand and merge the chunk result into the working sum.
   always_comb begin
      shift_s     = 32'(k_r) * 32'(CHUNK);
      a_chunk_s   = CHUNK'(a_r >> shift_s);
      b_chunk_s   = CHUNK'(b_r >> shift_s);
      work_next_s = (work_r & ~(CHUNK_MASK << shift_s)) | (WIDTH'(chunk_sum_s) << shift_s);
      last_s      = (k_r == KW'(NCH - 1));
   end

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a         (a_chunk_s),
      .b         (b_chunk_s),
      .carry_in  (carry_r),
      .sum       (chunk_sum_s),
      .carry_out (chunk_co_s),
      .carry_msb (chunk_cmsb_s)
   );

   // Control FSM, operand/index/carry registers and committed result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         k_r         <= {KW{1'b0}};
         work_r      <= {WIDTH{1'b0}};
         sum_r       <= {WIDTH{1'b0}};
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= carry_in;
                  k_r     <= {KW{1'b0}};
                  work_r  <= {WIDTH{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               carry_r <= chunk_co_s;
               work_r  <= work_next_s;
               if (last_s) begin
                  sum_r       <= work_next_s;
                  carry_out_r <= chunk_co_s;
                  overflow_r  <= chunk_cmsb_s ^ chunk_co_s;
                  done_r      <= 1'b1;
                  busy_r      <= 1'b0;
                  k_r         <= {KW{1'b0}};
                  state_r     <= IDLE;
               end else begin
                  done_r      <= 1'b0;
                  k_r         <= k_r + KW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign sum       = sum_r;
   assign carry_out = carry_out_r;
   assign overflow  = overflow_r;

endmodule
